// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI target with one-entry TX/RX buffers, all CPOL/CPHA modes, MSB/LSB framing
module spi_slave_core #(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD = '1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_i,
  input  logic                  clr_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_nss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_en_o,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  busy_o,
  output logic                  ovf_o,
  output logic                  udf_o
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_n;
  logic [2:0] sck_s, nss_s;
  logic [1:0] mosi_s;
  logic [DATA_WIDTH-1:0] tx_buf, tx_sr, rx_sr, rx_word;
  logic [CW-1:0] cnt;
  logic tx_full, skip;
  logic active, nss_fall, sck_rise, sck_fall, in_shift, sample, shift, done, load, accept;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      sck_s  <= '0;
      nss_s  <= '1;
      mosi_s <= '0;
      state  <= IDLE;
    end else begin
      sck_s  <= {sck_s[1:0], spi_sck_i};
      nss_s  <= {nss_s[1:0], spi_nss_i};
      mosi_s <= {mosi_s[0], spi_mosi_i};
      state  <= state_n;
    end
  always_comb begin
    active        = en_i & ~nss_s[1];
    nss_fall      = nss_s[2] & ~nss_s[1];
    sck_rise      = sck_s[1] & ~sck_s[2];
    sck_fall      = ~sck_s[1] & sck_s[2];
    in_shift      = state == SHIFT;
    sample        = in_shift & active & ((cpol_i == cpha_i) ? sck_rise : sck_fall);
    shift         = in_shift & active & ((cpol_i == cpha_i) ? sck_fall : sck_rise);
    rx_word       = lsb_i ? {mosi_s[1], rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], mosi_s[1]};
    done          = sample & (cnt == CW'(DATA_WIDTH - 1));
    load          = (state == LOAD) | done;
    accept        = tx_valid_i & ~tx_full;
    state_n       = !active ? IDLE : (state == IDLE) ? (nss_fall ? LOAD : IDLE) : SHIFT;
    spi_miso_en_o = in_shift;
    busy_o        = in_shift;
    spi_miso_o    = in_shift & (lsb_i ? tx_sr[0] : tx_sr[DATA_WIDTH-1]);
    tx_ready_o    = ~tx_full;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      tx_buf     <= '0;
      tx_full    <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      cnt        <= '0;
      skip       <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      ovf_o      <= 1'b0;
      udf_o      <= 1'b0;
    end else begin
      if (accept) tx_buf <= tx_data_i;
      tx_full <= accept | (tx_full & ~load);
      // a word completing mid-stream reloads TX and skips the shift edge that follows
      if (load) tx_sr <= tx_full ? tx_buf : FILL_WORD;
      else if (shift && !skip) tx_sr <= lsb_i ? tx_sr >> 1 : tx_sr << 1;
      skip <= load ? ((state == LOAD) ? cpha_i : 1'b1) : shift ? 1'b0 : skip;
      cnt  <= load ? '0 : sample ? cnt + 1'b1 : cnt;
      if (sample) rx_sr <= rx_word;
      if (done && (!rx_valid_o || rx_ready_i)) begin
        rx_data_o  <= rx_word;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      ovf_o <= (done & rx_valid_o & ~rx_ready_i) | (ovf_o & ~clr_i);
      udf_o <= (load & ~tx_full) | (udf_o & ~clr_i);
    end
endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- Standard-SPI (single MOSI/MISO) target for the SPI IP; it is the responder counterpart of spi_core.
- Oversamples an external SCK/NSS/MOSI in the clk_i domain and supports all four CPOL/CPHA modes and MSB/LSB-first framing.
- Exposes one-entry TX and RX word buffers with valid/ready handshakes toward the register/FIFO layer.
- Keeps sticky overflow and underflow flags.

Parameters:
- DATA_WIDTH, 8, frame length in bits (8..32).
- FILL_WORD, all-ones, word shifted out on MISO when the TX buffer is empty at frame load.

Ports:
- clk_i  in  1  system clock; must be at least 8x SCK frequency.
- rst_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  core enable; 0 = ignore bus, MISO high-z.
- cpol_i  in  1  SCK idle level.
- cpha_i  in  1  clock phase.
- lsb_i  in  1  1 = LSB first, 0 = MSB first.
- clr_i  in  1  single-cycle clear of ovf_o/udf_o.
- spi_sck_i  in  1  async SCK from master.
- spi_nss_i  in  1  async chip select, active low.
- spi_mosi_i  in  1  async serial data in.
- spi_miso_o  out  1  serial data out.
- spi_miso_en_o  out  1  MISO output enable.
- tx_valid_i  in  1  TX word offered.
- tx_ready_o  out  1  TX buffer empty.
- tx_data_i  in  DATA_WIDTH  TX word.
- rx_valid_o  out  1  RX word held.
- rx_ready_i  in  1  RX word consumed.
- rx_data_o  out  DATA_WIDTH  RX word.
- busy_o  out  1  frame in progress.
- ovf_o  out  1  sticky: RX word dropped.
- udf_o  out  1  sticky: FILL_WORD sent.

Behaviour:
- Reset values: spi_miso_o=0, spi_miso_en_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, busy_o=0, ovf_o=0, udf_o=0. Reset also clears the FSM, counters, shift registers and skip flag.
- Synchronisation:
  - 2-flop synchronisers on SCK, NSS and MOSI; a third SCK/NSS stage feeds the edge detect.
  - Synchronised edges lag the pins by 2-3 clk_i.
  - Sample edge is the rising edge when cpol_i==cpha_i, otherwise the falling edge; the shift edge is the opposite edge.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: miso_en=0, busy_o=0. On synced NSS falling edge with en_i=1, go to LOAD.
  - LOAD (1 cycle):
    - If the TX buffer is full, copy it to the TX shift register and set tx_ready_o=1 the next cycle.
    - Otherwise load FILL_WORD and set udf_o.
    - Bit counter=0; skip flag=cpha_i; go to SHIFT.
  - SHIFT:
    - miso_en=1; busy_o=1; spi_miso_o = shift-reg MSB (lsb_i=0) or LSB (lsb_i=1).
    - On a sample edge: shift synced MOSI into the RX shift register in lsb_i order and increment the counter.
    - On a shift edge: if the skip flag is set, clear it; otherwise advance the TX shift register by one.
    - When the counter reaches DATA_WIDTH on a sample edge:
      - Hand the RX word to the RX buffer.
      - Reload the TX shift register exactly as in LOAD, same cycle.
      - Set the skip flag=1 and reset the counter to 0.
    - Frames repeat back-to-back while NSS stays low.
  - Synced NSS high in any state returns to IDLE next cycle:
    - A partial RX word is discarded.
    - A TX word already loaded is consumed, not returned.
    - miso_en drops.
- RX buffer:
  - On word completion, if rx_valid_o=0 or rx_ready_i=1 in the same cycle: rx_data_o<=word, rx_valid_o<=1.
  - Otherwise the word is dropped, rx_data_o is unchanged and ovf_o is set.
  - rx_valid_o falls the cycle after rx_valid_o&rx_ready_i unless a new word completes in that same cycle.
- TX buffer:
  - Accepts when tx_valid_i&tx_ready_o, after which tx_ready_o=0.
  - An accept in the same cycle as a load is not seen by that load; it becomes the next word.
- Flags:
  - clr_i clears ovf_o/udf_o; a set event in the same cycle wins.
- en_i=0:
  - Forces IDLE; buffers and flags are retained.
  - en_i rising while NSS is already low waits for the next NSS falling edge.
- Mode change: cpol_i/cpha_i/lsb_i are only required to be stable while busy_o=1.

Test Plan:
- Mode 0, MSB-first, DATA_WIDTH=8, TX preloaded 0xA5; master sends 0x3C -> MISO bit sequence 1,0,1,0,0,1,0,1; rx_data_o=0x3C with rx_valid_o=1; tx_ready_o=1 after LOAD; udf_o=0.
- Modes 1, 2 and 3, lsb_i=1, TX 0x81, master sends 0x12 -> master reads 0x81; rx_data_o=0x12 in every mode.
- Back-to-back frames with TX empty for the 2nd frame; master sends 0x11,0x22 -> 2nd MISO word=0xFF; udf_o=1; clr_i clears it.
- RX overflow: rx_ready_i held 0; three frames 0x01,0x02,0x03 -> rx_data_o=0x01, ovf_o=1 after frame 2; asserting rx_ready_i then yields rx_valid_o=0.
- NSS deasserted after 5 bits, then a full frame 0x5A -> no RX from the aborted frame; next rx_data_o=0x5A; busy_o low between frames.
- rst_n_i asserted mid-frame -> every output returns to its reset value asynchronously; the next full frame works normally.
